// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared constants and pulse-FSM state type for the button conditioner
package tetris_pkg;

    // Channel indices into the button vectors
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;
    localparam int BTN_S = 3;
    localparam int N_BTN = 4;

    // Default timing at 100 MHz: 10 ms debounce, 300 ms first repeat, 100 ms repeat period
    localparam int DEF_DEBOUNCE_CYC    = 1000000;
    localparam int DEF_REPEAT_DLY_CYC  = 30000000;
    localparam int DEF_REPEAT_RATE_CYC = 10000000;

    // Drop (S) never auto-repeats by default
    localparam logic [N_BTN-1:0] DEF_REPEAT_MASK = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } btn_state_t;

endpackage

// File: rtl/tetris_btn_chan.sv
// rtl/tetris_btn_chan.sv - one button channel: sync, debounce, press/auto-repeat pulse (TETRIS_BTN_REPEAT_EN)
module tetris_btn_chan
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC
`ifdef TETRIS_BTN_REPEAT_EN
    ,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DLY_CYC  = DEF_REPEAT_DLY_CYC,
    parameter int REPEAT_RATE_CYC = DEF_REPEAT_RATE_CYC
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC);

    logic            sync1;
    logic            sync2;
    logic            level_int;  // accepted level; btn_level follows it one cycle later
    logic [DB_W-1:0] db_cnt;

    // Two-flop synchroniser for the asynchronous pushbutton
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            level_int <= 1'b0;
        end else if (sync2 == level_int) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            level_int <= sync2;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Registered level output; level_int & ~btn_level marks the first cycle of a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b0;
        end else begin
            btn_level <= level_int;
        end
    end

`ifdef TETRIS_BTN_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC : REPEAT_RATE_CYC;
    localparam int RP_W   = $clog2(RP_MAX);

    btn_state_t      state;
    logic [RP_W-1:0] rp_cnt;

    // Pulse FSM: press pulse, then delayed repeats while held; a release cancels any pending pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rp_cnt    <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    rp_cnt <= '0;
                    if (level_int && !btn_level) begin
                        btn_pulse <= 1'b1;
                        if (REPEAT_EN) begin
                            state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (!level_int) begin
                        state  <= IDLE;
                        rp_cnt <= '0;
                    end else if (rp_cnt == RP_W'(REPEAT_DLY_CYC - 1)) begin
                        btn_pulse <= 1'b1;
                        state     <= REPEAT;
                        rp_cnt    <= '0;
                    end else begin
                        rp_cnt <= rp_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level_int) begin
                        state  <= IDLE;
                        rp_cnt <= '0;
                    end else if (rp_cnt == RP_W'(REPEAT_RATE_CYC - 1)) begin
                        btn_pulse <= 1'b1;
                        rp_cnt    <= '0;
                    end else begin
                        rp_cnt <= rp_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                end
            endcase
        end
    end
`else
    // Single strobe on each debounced press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= level_int & ~btn_level;
        end
    end
`endif

endmodule

// File: rtl/tetris_btn_cond.sv
// rtl/tetris_btn_cond.sv - four-channel button conditioner feeding tetris_main (TETRIS_BTN_REPEAT_EN)
module tetris_btn_cond #(
    parameter int                N_BTN           = tetris_pkg::N_BTN,
    parameter int                DEBOUNCE_CYC    = tetris_pkg::DEF_DEBOUNCE_CYC,
    parameter int                REPEAT_DLY_CYC  = tetris_pkg::DEF_REPEAT_DLY_CYC,
    parameter int                REPEAT_RATE_CYC = tetris_pkg::DEF_REPEAT_RATE_CYC,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = tetris_pkg::DEF_REPEAT_MASK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    // Independent channels, no cross-channel priority
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        tetris_btn_chan #(
            .DEBOUNCE_CYC    (DEBOUNCE_CYC)
`ifdef TETRIS_BTN_REPEAT_EN
            ,
            .REPEAT_EN       (REPEAT_MASK[i]),
            .REPEAT_DLY_CYC  (REPEAT_DLY_CYC),
            .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .btn_pulse (btn_pulse[i])
        );
    end

endmodule
